bcd2bin_seq: RTL and testbench
==============================

# bcd2bin_seq

Sequential BCD-to-binary converter: the inverse of the score/length combinational binary-to-BCD path. Accepts a 4-digit packed BCD value over a valid/ready handshake, converts it with iterative reverse double-dabble (shift-right, subtract-3), and presents a 16-bit binary result over a second valid/ready handshake. Used where decimal values (keypad/UART-entered settings, stored high scores) must be turned back into binary for game logic.

## Interface
- No parameters; widths fixed (4 BCD digits in, 16-bit binary out).
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  `bcd` holds a value to convert
- `in_ready`  out  1  converter idle and accepting; high only in IDLE
- `bcd`  in  16  packed BCD, [15:12] thousands … [3:0] units
- `out_valid`  out  1  `bin`/`err` valid; high only in DONE
- `out_ready`  in  1  consumer takes result
- `bin`  out  16  binary result, 0..9999 (bits [15:14] always 0 for legal input)
- `err`  out  1  input contained a digit > 9 (see Configuration)

## Operation
- Working register `sr[31:0]`; upper 16 = BCD digits, lower 16 = binary accumulator; 4-bit iteration counter `cnt`.
- States IDLE, CONV, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: `sr <= {bcd, 16'h0000}`, `cnt <= 0`, → CONV (or → DONE with error, see Configuration).
- CONV: each cycle `sr` shifts right 1 (zero fill); then every nibble `sr[31:28]`,`[27:24]`,`[23:20]`,`[19:16]` that is ≥ 8 has 3 subtracted (4-bit, no borrow out). `cnt` increments; on the cycle with `cnt==15` → DONE, `bin <= sr_next[15:0]`, `out_valid <= 1`.
- DONE: `bin`, `err` held stable while `out_valid && !out_ready`. On `out_valid && out_ready` → IDLE, `out_valid <= 0`.
- `in_valid` outside IDLE ignored; `bcd` sampled only on the accepting edge.
- No overlap: a new input is never accepted in the cycle the result is consumed.

## Timing
- Reset (`rst_n` low at an edge): state IDLE, `out_valid`=0, `bin`=0, `err`=0, `cnt`=0, `sr`=0; `in_ready`=1 from the first edge after release.
- Reset mid-CONV or in DONE: conversion abandoned, no `out_valid` pulse, result lost.
- Latency: accept at edge E; iterations at edges E+1..E+16; `out_valid` high after edge E+16.
- Minimum cycle per conversion: 18 clocks (accept, 16 CONV, 1 DONE with `out_ready`=1), then IDLE one cycle before next accept.
- `in_ready` and `out_valid` are decoded from registered state only; no combinational path from `in_valid`/`out_ready` to either.

## Configuration
- `BCD2BIN_DIGIT_CHECK_EN` defined: on accept, any nibble of `bcd` > 9 → skip CONV, go directly to DONE after edge E+1 with `bin`=0, `err`=1. Legal input yields `err`=0.
- Not defined: no check; `err` tied 0; illegal digits run through the 16 iterations and `bin` is whatever the algorithm produces (deterministic, unspecified); latency always 16.

## Test plan
- Reset then `bcd`=16'h1234, `out_ready`=1 → `out_valid` after exactly 16 edges post-accept, `bin`=16'h04D2, `err`=0, then `in_ready`=1.
- Boundary values 16'h0000 → 0; 16'h9999 → 16'h270F; 16'h0009 → 9; 16'h1000 → 16'h03E8.
- `out_ready` low 5 cycles in DONE → `out_valid`, `bin` held unchanged; `in_valid` pulses with new `bcd` during CONV/DONE ignored, `in_ready`=0.
- With `BCD2BIN_DIGIT_CHECK_EN`: `bcd`=16'h12A4 → `out_valid` one edge after accept, `err`=1, `bin`=0; next legal 16'h0042 → `bin`=16'h002A, `err`=0.
- `rst_n` low for one edge at the 8th CONV cycle of 16'h5678 → IDLE, no `out_valid`, outputs 0; following 16'h5678 → 16'h162E.
- Back-to-back random legal BCD (≥1000 vectors) with random `out_ready` stalls → every result equals decimal value, no drop/duplicate.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential 4-digit packed BCD to 16-bit binary converter.
// Uses reverse double-dabble: 16 iterations of shift-right, then subtract 3
// from every BCD nibble that is >= 8.
// Optional feature macro: BCD2BIN_DIGIT_CHECK_EN.
// - When it is defined, any input digit > 9 skips conversion.
// - The result then comes back with err=1 and bin=0.
// - When it is undefined, err is tied to 0.
module bcd2bin_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] bcd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] bin,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] sr_reg;
  logic [31:0] sr_shift;
  logic [31:0] sr_next;
  logic [3:0]  cnt_reg;
  logic [15:0] bin_reg;
  logic        conv_abort;

  // One iteration: shift right with zero fill, then correct each BCD nibble.
  assign sr_shift      = {1'b0, sr_reg[31:1]};
  assign sr_next[15:0] = sr_shift[15:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign sr_next[16+4*gi +: 4] = (sr_shift[16+4*gi +: 4] >= 4'd8)
                                     ? (sr_shift[16+4*gi +: 4] - 4'd3)
                                     : sr_shift[16+4*gi +: 4];
    end
  endgenerate

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic [3:0] digit_bad;
  logic       bad_reg;
  logic       err_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chk
      assign digit_bad[gi] = (bcd[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign conv_abort = bad_reg;
  assign err        = err_reg;
`else
  assign conv_abort = 1'b0;
  assign err        = 1'b0;
`endif

  // Handshake flags come only from the registered state.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign bin       = bin_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = CONV;
      CONV: if (conv_abort || (cnt_reg == 4'd15)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in CONV, capture the result on exit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_reg  <= 32'h0;
      cnt_reg <= 4'd0;
      bin_reg <= 16'h0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      bad_reg <= 1'b0;
      err_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sr_reg  <= {bcd, 16'h0000};
            cnt_reg <= 4'd0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_reg <= |digit_bad;
`endif
          end
        end
        CONV: begin
          sr_reg  <= sr_next;
          cnt_reg <= cnt_reg + 4'd1;
          if (conv_abort) begin
            bin_reg <= 16'h0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_reg <= 1'b1;
`endif
          end else if (cnt_reg == 4'd15) begin
            bin_reg <= sr_next[15:0];
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_reg <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: randomized self-checking bench for bcd2bin_seq.
// The reference value of a BCD word is its decimal value.
// It is computed with plain arithmetic on the digits.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] bin;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd2bin_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: decimal value of a packed BCD word.
  function automatic int bcd_value(input logic [15:0] v);
    return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  // Run one conversion.
  // Junk input stays asserted while the converter is busy.
  // The result is held for 'stall' cycles before it is consumed.
  task automatic convert(input logic [15:0] v, input int stall);
    int lat;
    int n;
    logic [15:0] exp;
    exp = 16'(bcd_value(v));
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bcd = v;
    step();
    bcd = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == 3) check("in_ready_busy", 32'(in_ready), 32'd0);
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'd16);
    check("out_valid", 32'(out_valid), 32'd1);
    check("bin", 32'(bin), 32'(exp));
    check("err", 32'(err), 32'd0);
    for (int i = 0; i < stall; i++) begin
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_bin", 32'(bin), 32'(exp));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
    $display("xfer bcd=%04h bin=%04h exp=%04h lat=%0d stall=%0d", v, bin, exp, lat, stall);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    bcd = 16'h0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bin", 32'(bin), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    convert(16'h1234, 0);
    check("val_1234", 32'(bin), 32'h04D2);
    convert(16'h0000, 0);
    convert(16'h9999, 1);
    check("val_9999", 32'(bin), 32'h270F);
    convert(16'h0009, 0);
    convert(16'h1000, 5);
    check("val_1000", 32'(bin), 32'h03E8);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    in_valid = 1'b1;
    bcd = 16'h12A4;
    step();
    in_valid = 1'b0;
    step();
    check("chk_valid", 32'(out_valid), 32'd1);
    check("chk_err", 32'(err), 32'd1);
    check("chk_bin", 32'(bin), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    $display("xfer bcd=12a4 err=1 (illegal digit)");
    convert(16'h0042, 0);
    check("val_0042", 32'(bin), 32'h002A);
`endif

    // Reset in the middle of a conversion abandons it.
    in_valid = 1'b1;
    bcd = 16'h5678;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bin", 32'(bin), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (out_valid) seen = 1'b1;
      end
      check("mid_rst_no_valid", 32'(seen), 32'd0);
    end
    $display("xfer bcd=5678 aborted by reset");
    convert(16'h5678, 0);
    check("val_5678", 32'(bin), 32'h162E);

    // Random legal values with random consumer stalls.
    for (int k = 0; k < 1000; k++) begin
      convert(to_bcd(int'($urandom_range(0, 9999))), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
